// File: rtl/l2_msg_pkg.sv
// Shared constants for the L2 message scheduler: message type codes,
// FSM state encoding and default field widths.
package l2_msg_pkg;

  localparam int unsigned TAG_W_DEF  = 26;
  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned SRC_W_DEF  = 6;
  localparam int unsigned TYPE_W     = 8;
  localparam int unsigned CNT_W      = 8;

  localparam logic [TYPE_W-1:0] LOAD_REQ     = 8'h1F;
  localparam logic [TYPE_W-1:0] LOAD_MEM     = 8'h13;
  localparam logic [TYPE_W-1:0] LOAD_MEM_ACK = 8'h18;
  localparam logic [TYPE_W-1:0] DATA_ACK     = 8'h25;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } msg_state_e;

endpackage

// File: rtl/l2_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
// Ports: clk, rst_n (sync, active-low), clr (priority over en), en, cnt.
module l2_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Counts up while enabled and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/l2_msg_sched.sv
// Single-line L2 message scheduler: accepts core load requests (msg1),
// answers hits directly, fetches misses from memory (msg2 LOAD_MEM / msg3 ack)
// and returns DATA_ACK on msg2.
// Ports: clk, rst_n (sync, active-low); msg1_* core request in; msg3_* memory
// response in; msg2_* outbound message; cache_* line state; cur_msg_* captured
// request; cur_msg_state FSM state; mem_wait_cnt wait-cycle counter;
// unsup_pulse flags a dropped request.
module l2_msg_sched
  import l2_msg_pkg::*;
#(
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SRC_W  = SRC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              msg1_valid,
  output logic              msg1_ready,
  input  logic [7:0]        msg1_type,
  input  logic [TAG_W-1:0]  msg1_tag,
  input  logic [SRC_W-1:0]  msg1_source,
  input  logic              msg3_valid,
  output logic              msg3_ready,
  input  logic [7:0]        msg3_type,
  input  logic [DATA_W-1:0] msg3_data,
  output logic              msg2_valid,
  input  logic              msg2_ready,
  output logic [7:0]        msg2_type,
  output logic [TAG_W-1:0]  msg2_tag,
  output logic [SRC_W-1:0]  msg2_dest,
  output logic [DATA_W-1:0] msg2_data,
  output logic [TAG_W-1:0]  cache_tag,
  output logic [1:0]        cache_vd,
  output logic [DATA_W-1:0] cache_data,
  output logic [1:0]        cur_msg_state,
  output logic [7:0]        cur_msg_type,
  output logic [TAG_W-1:0]  cur_msg_tag,
  output logic [SRC_W-1:0]  cur_msg_source,
  output logic [7:0]        mem_wait_cnt,
  output logic              unsup_pulse
);

  msg_state_e        state, state_d;
  logic [7:0]        cur_type_d;
  logic [TAG_W-1:0]  cur_tag_d;
  logic [SRC_W-1:0]  cur_src_d;
  logic [TAG_W-1:0]  cache_tag_d;
  logic [1:0]        cache_vd_d;
  logic [DATA_W-1:0] cache_data_d;
  logic              unsup_d;
  logic              msg2_valid_d;
  logic [7:0]        msg2_type_d;
  logic [TAG_W-1:0]  msg2_tag_d;
  logic [SRC_W-1:0]  msg2_dest_d;
  logic [DATA_W-1:0] msg2_data_d;

  // Handshake readiness depends on state alone.
  assign msg1_ready    = (state == IDLE);
  assign msg3_ready    = (state == MEM_WAIT);
  assign cur_msg_state = 2'(state);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cur_msg_type   <= '0;
      cur_msg_tag    <= '0;
      cur_msg_source <= '0;
      cache_tag      <= '0;
      cache_vd       <= '0;
      cache_data     <= '0;
      unsup_pulse    <= 1'b0;
      msg2_valid     <= 1'b0;
      msg2_type      <= '0;
      msg2_tag       <= '0;
      msg2_dest      <= '0;
      msg2_data      <= '0;
    end else begin
      state          <= state_d;
      cur_msg_type   <= cur_type_d;
      cur_msg_tag    <= cur_tag_d;
      cur_msg_source <= cur_src_d;
      cache_tag      <= cache_tag_d;
      cache_vd       <= cache_vd_d;
      cache_data     <= cache_data_d;
      unsup_pulse    <= unsup_d;
      msg2_valid     <= msg2_valid_d;
      msg2_type      <= msg2_type_d;
      msg2_tag       <= msg2_tag_d;
      msg2_dest      <= msg2_dest_d;
      msg2_data      <= msg2_data_d;
    end
  end

  // Next state, captured request, line update and next msg2 payload.
  always_comb begin
    state_d      = state;
    cur_type_d   = cur_msg_type;
    cur_tag_d    = cur_msg_tag;
    cur_src_d    = cur_msg_source;
    cache_tag_d  = cache_tag;
    cache_vd_d   = cache_vd;
    cache_data_d = cache_data;
    unsup_d      = 1'b0;
    msg2_valid_d = 1'b0;
    msg2_type_d  = '0;
    msg2_tag_d   = '0;
    msg2_dest_d  = '0;
    msg2_data_d  = '0;

    unique case (state)
      IDLE: begin
        if (msg1_valid) begin
          if (msg1_type == LOAD_REQ) begin
            cur_type_d = msg1_type;
            cur_tag_d  = msg1_tag;
            cur_src_d  = msg1_source;
            state_d    = (cache_vd[1] && (cache_tag == msg1_tag)) ? RESP : MEM_REQ;
          end else begin
            unsup_d = 1'b1;
          end
        end
      end
      MEM_REQ: begin
        if (msg2_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (msg3_valid && (msg3_type == LOAD_MEM_ACK)) begin
          cache_tag_d  = cur_msg_tag;
          cache_vd_d   = 2'b10;
          cache_data_d = msg3_data;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (msg2_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // msg2 is registered, so its payload follows the state being entered;
    // values are unchanged while a stalled message holds its state.
    unique case (state_d)
      MEM_REQ: begin
        msg2_valid_d = 1'b1;
        msg2_type_d  = LOAD_MEM;
        msg2_tag_d   = cur_tag_d;
      end
      RESP: begin
        msg2_valid_d = 1'b1;
        msg2_type_d  = DATA_ACK;
        msg2_tag_d   = cur_tag_d;
        msg2_dest_d  = cur_src_d;
        msg2_data_d  = cache_data_d;
      end
      default: ;
    endcase
  end

  // Wait counter clears on the edge that enters MEM_WAIT.
  l2_sat_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state == MEM_REQ) && msg2_ready),
    .en   (state == MEM_WAIT),
    .cnt  (mem_wait_cnt)
  );

endmodule
